pixel_fetch: RTL and testbench
==============================

PIXEL_FETCH -- requirements
Module: pixel_fetch

Interface
REQ-001 Parameters, one per line (name, default, meaning):
- H_ACTIVE, 320, visible pixels per line
- V_ACTIVE, 480, visible display lines; each source line is shown twice
- V_TOTAL, 525, display lines per frame
- ADDR_W, 17, framebuffer word address width
- DATA_W, 8, pixel width
REQ-002 Ports, one per line (name, direction, width, meaning):
- clock  in  1  pixel clock; single clock domain
- reset  in  1  synchronous, active-high reset
- hblank  in  1  horizontal blank from the horizontal counter
- row_done  in  1  one-cycle end-of-line pulse from the horizontal counter
- vblank  out  1  high while display line >= V_ACTIVE
- vsync  out  1  active-low, low on display lines 490-491
- mem_req  out  1  framebuffer read request
- mem_addr  out  ADDR_W  framebuffer word address
- mem_ack  in  1  one-cycle acknowledge; mem_data valid in the same cycle
- mem_data  in  DATA_W  read data
- pixel  out  DATA_W  pixel to the DAC
- pixel_valid  out  1  pixel is displayable
- underrun  out  1  sticky error flag

Function
REQ-003 The line counter SHALL count 0..V_TOTAL-1, advance on each row_done, and wrap V_TOTAL-1 -> 0.
REQ-004 vblank and vsync SHALL be registered and SHALL change in the same edge that updates the line counter.
REQ-005 The pixel index SHALL clear on row_done, increment on each clock with hblank=0, and saturate at H_ACTIVE-1.
REQ-006 The line buffer SHALL be two banks of H_ACTIVE x DATA_W: the display bank is selected by disp_bank and the fetch bank is its complement.
REQ-007 On row_done into new line n, disp_bank SHALL toggle if n==0 or (n even and n<V_ACTIVE).
REQ-008 At each such toggle, if the fetch FSM is not in DONE, underrun SHALL be set; the toggle SHALL still occur.
REQ-009 On row_done into line V_TOTAL-1, a fetch of source line 0 SHALL start; on row_done into even n < V_ACTIVE-2, a fetch of source line n/2+1 SHALL start.
REQ-010 The fetch FSM SHALL have states IDLE, REQ and DONE:
- IDLE -> REQ on a fetch start
- REQ -> DONE when word H_ACTIVE-1 is acknowledged
- DONE -> IDLE on the next bank toggle
- a fetch start in any state SHALL restart at word 0
REQ-011 A fetch start arriving while the FSM is in REQ SHALL additionally set underrun.
REQ-012 In REQ, mem_req SHALL be high and mem_addr SHALL hold base + word index stable until mem_ack.
REQ-013 On mem_ack, mem_data SHALL be written to the fetch bank at the word index and the index SHALL increment; the next request follows back-to-back with no idle cycle.
REQ-014 mem_ack SHALL be ignored outside REQ.
REQ-015 base SHALL equal source line x H_ACTIVE, formed by adding H_ACTIVE per fetch from 0 without a multiplier, and SHALL be held modulo 2^ADDR_W.
REQ-016 pixel and pixel_valid SHALL be registered with 1-clock latency from the pixel index.
REQ-017 pixel_valid SHALL equal !hblank & !vblank & primed; pixel SHALL be the display-bank entry when pixel_valid, else 0.
REQ-018 primed SHALL be set by the first bank toggle taken with the FSM in DONE, and SHALL be cleared only by reset.

Reset
REQ-019 With reset high at a clock edge, the following SHALL take effect at that edge:
- line counter, pixel index, word index, base, disp_bank <= 0
- FSM <= IDLE
- vblank <= 0, vsync <= 1
- mem_req <= 0, mem_addr <= 0
- pixel <= 0, pixel_valid <= 0
- underrun <= 0, primed <= 0
REQ-020 Reset SHALL override all inputs and SHALL abort any fetch in progress mid-operation; buffer contents need not be cleared.

Verification
REQ-021 The bench SHALL cover these directed scenarios:
- Drive 525 row_done pulses with a zero-wait memory -> vblank rises entering line 480; vsync is low exactly on lines 490-491; the counter wraps to 0.
- Fill memory with address&0xFF, run 2 frames -> the 2nd frame line 2k shows pixel i = (k*320+i)&0xFF, 1 clock after index i, with pixel_valid=1.
- Hold mem_ack low 3 clocks per word -> mem_addr is stable while mem_req is high; all 320 words are written; underrun stays 0.
- Never assert mem_ack -> underrun sets at the line-0 toggle; pixel_valid stays 0 (primed=0).
- Assert reset mid-fetch at word 100 -> mem_req=0 next clock; all outputs hold their REQ-019 values.
- Pulse row_done twice within 10 clocks during REQ -> underrun=1; the fetch restarts at word 0.

Source files
------------

// File: rtl/pixel_fetch.sv
// Vertical timing, line-buffer prefetch and pixel readout for a line-doubled display.
// Each source line is fetched into the idle bank while the other bank is scanned out twice.
module pixel_fetch #(
  parameter int H_ACTIVE = 320,
  parameter int V_ACTIVE = 480,
  parameter int V_TOTAL  = 525,
  parameter int ADDR_W   = 17,
  parameter int DATA_W   = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              hblank,
  input  logic              row_done,
  output logic              vblank,
  output logic              vsync,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_data,
  output logic [DATA_W-1:0] pixel,
  output logic              pixel_valid,
  output logic              underrun
);

  localparam int LINE_W = $clog2(V_TOTAL);
  localparam int IDX_W  = $clog2(H_ACTIVE);

  localparam logic [LINE_W-1:0] LINE_LAST   = LINE_W'(V_TOTAL - 1);
  localparam logic [LINE_W-1:0] LINE_VACT   = LINE_W'(V_ACTIVE);
  localparam logic [LINE_W-1:0] LINE_FLIMIT = LINE_W'(V_ACTIVE - 2);
  localparam logic [LINE_W-1:0] VS_FIRST    = LINE_W'(490);
  localparam logic [LINE_W-1:0] VS_LAST     = LINE_W'(491);
  localparam logic [IDX_W-1:0]  IDX_LAST    = IDX_W'(H_ACTIVE - 1);
  localparam logic [ADDR_W-1:0] LINE_STRIDE = ADDR_W'(H_ACTIVE);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [LINE_W-1:0] line_cnt;
  logic [LINE_W-1:0] line_next;
  logic [IDX_W-1:0]  pix_idx;
  logic [IDX_W-1:0]  word_idx;
  logic [ADDR_W-1:0] base;
  logic [ADDR_W-1:0] fetch_base;
  logic [1:0]        state;
  logic              disp_bank;
  logic              primed;
  logic              bank_toggle;
  logic              fetch_start;
  logic              ack_take;
  logic              disp_on;

  logic [DATA_W-1:0] lbuf [2][H_ACTIVE];

  always_comb begin
    line_next   = (line_cnt == LINE_LAST) ? '0 : line_cnt + 1'b1;
    bank_toggle = row_done && ((line_next == '0) ||
                               (!line_next[0] && (line_next < LINE_VACT)));
    fetch_start = row_done && ((line_next == LINE_LAST) ||
                               (!line_next[0] && (line_next < LINE_FLIMIT)));
    // Source line 0 restarts the running base; every other fetch is one line further on.
    fetch_base  = (line_next == LINE_LAST) ? '0 : base + LINE_STRIDE;
    ack_take    = (state == S_REQ) && mem_ack;
    disp_on     = !hblank && !vblank && primed;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      line_cnt    <= '0;
      pix_idx     <= '0;
      word_idx    <= '0;
      base        <= '0;
      disp_bank   <= 1'b0;
      state       <= S_IDLE;
      vblank      <= 1'b0;
      vsync       <= 1'b1;
      mem_req     <= 1'b0;
      mem_addr    <= '0;
      pixel       <= '0;
      pixel_valid <= 1'b0;
      underrun    <= 1'b0;
      primed      <= 1'b0;
    end else begin
      if (row_done) begin
        line_cnt <= line_next;
        vblank   <= (line_next >= LINE_VACT);
        vsync    <= !((line_next == VS_FIRST) || (line_next == VS_LAST));
      end

      if (row_done)
        pix_idx <= '0;
      else if (!hblank && (pix_idx != IDX_LAST))
        pix_idx <= pix_idx + 1'b1;

      if (bank_toggle) begin
        disp_bank <= ~disp_bank;
        if (state != S_DONE)
          underrun <= 1'b1;
        else
          primed <= 1'b1;
      end

      // A new fetch always wins: it aborts whatever the FSM was doing.
      if (fetch_start) begin
        if (state == S_REQ)
          underrun <= 1'b1;
        state    <= S_REQ;
        base     <= fetch_base;
        word_idx <= '0;
        mem_req  <= 1'b1;
        mem_addr <= fetch_base;
      end else if (bank_toggle && (state == S_DONE)) begin
        state <= S_IDLE;
      end else if (ack_take) begin
        if (word_idx == IDX_LAST) begin
          state   <= S_DONE;
          mem_req <= 1'b0;
        end else begin
          word_idx <= word_idx + 1'b1;
          mem_addr <= base + ADDR_W'(word_idx) + ADDR_W'(1);
        end
      end

      // Readout stage: one clock from pixel index to DAC output.
      pixel_valid <= disp_on;
      pixel       <= disp_on ? lbuf[disp_bank][pix_idx] : '0;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset && ack_take && !fetch_start)
      lbuf[~disp_bank][word_idx] <= mem_data;
  end

endmodule

// File: tb/tb_pixel_fetch.sv
// Directed bench for pixel_fetch: vertical timing, prefetch/readout, slow memory,
// missing memory, reset mid-fetch and fetch restart.
module tb_pixel_fetch;

  logic        clock;
  logic        reset;
  logic        hblank;
  logic        row_done;
  logic        vblank;
  logic        vsync;
  logic        mem_req;
  logic [16:0] mem_addr;
  logic        mem_ack;
  logic [7:0]  mem_data;
  logic [7:0]  pixel;
  logic        pixel_valid;
  logic        underrun;

  int total = 0;
  int bad   = 0;

  // memory responder controls (written by the stimulus only)
  bit ack_en = 0;
  int wait_n = 0;
  // responder state (written by the responder only)
  int          wcnt = 0;
  int          ack_cnt = 0;
  int          unstable_cnt = 0;
  logic        prev_req = 0;
  logic        prev_ack = 0;
  logic [16:0] prev_addr = '0;

  logic [7:0] exp_pix_q [$];
  logic       exp_vld_q [$];

  pixel_fetch dut (
    .clock      (clock),
    .reset      (reset),
    .hblank     (hblank),
    .row_done   (row_done),
    .vblank     (vblank),
    .vsync      (vsync),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_ack    (mem_ack),
    .mem_data   (mem_data),
    .pixel      (pixel),
    .pixel_valid(pixel_valid),
    .underrun   (underrun)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Framebuffer model: word at address a holds a & 0xFF, answered after wait_n idle clocks.
  initial begin
    mem_ack  = 1'b0;
    mem_data = '0;
  end
  always @(negedge clock) begin
    if (ack_en && mem_req) begin
      if (wcnt >= wait_n) begin
        mem_ack  = 1'b1;
        mem_data = mem_addr[7:0];
        wcnt     = 0;
        ack_cnt  = ack_cnt + 1;
      end else begin
        mem_ack = 1'b0;
        wcnt    = wcnt + 1;
      end
    end else begin
      mem_ack = 1'b0;
      wcnt    = 0;
    end
    if (prev_req && mem_req && !prev_ack && (mem_addr !== prev_addr))
      unstable_cnt = unstable_cnt + 1;
    prev_req  = mem_req;
    prev_addr = mem_addr;
    prev_ack  = mem_ack;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic pulse();
    hblank   = 1'b1;
    row_done = 1'b1;
    tick();
    row_done = 1'b0;
  endtask

  task automatic do_reset();
    hblank   = 1'b1;
    row_done = 1'b0;
    reset    = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  // n fast lines: row_done followed by one blank clock
  task automatic fast_lines(input int n);
    for (int j = 0; j < n; j++) begin
      pulse();
      tick();
    end
  endtask

  task automatic blank(input int n);
    hblank = 1'b1;
    repeat (n) tick();
  endtask

  // One active line; expected pixel i is (addr0+i)&0xFF when vld, else 0.
  task automatic active_line(input string tag, input int addr0, input bit vld);
    logic [7:0] ep;
    logic       ev;
    for (int i = 0; i < 320; i++) begin
      hblank = 1'b0;
      ep = vld ? 8'(addr0 + i) : 8'h00;
      exp_pix_q.push_back(ep);
      exp_vld_q.push_back(vld);
      tick();
      ev = exp_vld_q.pop_front();
      ep = exp_pix_q.pop_front();
      check({tag, "_valid"}, pixel_valid, ev);
      check({tag, "_pixel"}, pixel, ep);
    end
    hblank = 1'b1;
  endtask

  initial begin
    logic reached;
    int   line_no;
    int   snap_ack;
    int   snap_unst;

    reset    = 1'b1;
    hblank   = 1'b1;
    row_done = 1'b0;
    repeat (3) tick();
    check("rst_vblank", vblank, 0);
    check("rst_vsync", vsync, 1);
    check("rst_mem_req", mem_req, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_pixel", pixel, 0);
    check("rst_pixel_valid", pixel_valid, 0);
    check("rst_underrun", underrun, 0);
    reset = 1'b0;

    // Vertical timing over one full frame with a zero-wait memory
    ack_en = 1;
    wait_n = 0;
    tick();
    for (int j = 1; j <= 525; j++) begin
      pulse();
      line_no = j % 525;
      check("s1_vblank", vblank, (line_no >= 480) ? 1 : 0);
      check("s1_vsync", vsync, ((line_no == 490) || (line_no == 491)) ? 0 : 1);
      if (j == 1)
        check("s1_no_underrun_odd_line", underrun, 0);
      tick();
    end

    // Prefetch and line-doubled readout in the second frame
    do_reset();
    ack_en = 1;
    wait_n = 0;
    fast_lines(523);
    pulse();
    check("s2_fetch0_addr", mem_addr, 0);
    check("s2_fetch0_req", mem_req, 1);
    blank(340);
    check("s2_fetch0_done", mem_req, 0);
    pulse();
    check("s2_line0_vblank", vblank, 0);
    for (int l = 0; l < 5; l++) begin
      active_line("s2_line", (l / 2) * 320, 1);
      blank(20);
      pulse();
    end

    // Slow memory: three idle clocks before each acknowledge
    do_reset();
    ack_en = 1;
    wait_n = 3;
    pulse();
    tick();
    pulse();
    check("s3_fetch_addr", mem_addr, 320);
    check("s3_underrun_line2_toggle", underrun, 1);
    snap_ack  = ack_cnt;
    snap_unst = unstable_cnt;
    blank(1320);
    check("s3_words_acked", ack_cnt - snap_ack, 320);
    check("s3_addr_stable", unstable_cnt - snap_unst, 0);
    check("s3_fetch_done", mem_req, 0);
    pulse();
    tick();
    pulse();
    active_line("s3_line4", 320, 1);

    // Memory never answers
    do_reset();
    ack_en = 0;
    fast_lines(523);
    pulse();
    blank(340);
    check("s4_still_req", mem_req, 1);
    pulse();
    check("s4_underrun", underrun, 1);
    check("s4_restart_addr", mem_addr, 320);
    active_line("s4_line0", 0, 0);

    // Reset in the middle of a fetch
    do_reset();
    ack_en = 1;
    wait_n = 0;
    pulse();
    tick();
    pulse();
    snap_ack = ack_cnt;
    reached  = 1'b0;
    for (int t = 0; t < 1000; t++) begin
      if (ack_cnt - snap_ack >= 100) begin
        reached = 1'b1;
        break;
      end
      tick();
    end
    check("s5_word100_reached", reached, 1);
    check("s5_req_before_reset", mem_req, 1);
    reset = 1'b1;
    tick();
    check("s5_mem_req", mem_req, 0);
    check("s5_mem_addr", mem_addr, 0);
    check("s5_vblank", vblank, 0);
    check("s5_vsync", vsync, 1);
    check("s5_pixel", pixel, 0);
    check("s5_pixel_valid", pixel_valid, 0);
    check("s5_underrun", underrun, 0);
    reset = 1'b0;
    tick();
    check("s5_idle_after", mem_req, 0);

    // Fetch restart while a fetch is still in progress
    do_reset();
    ack_en = 1;
    wait_n = 0;
    pulse();
    tick();
    pulse();
    repeat (5) tick();
    check("s6_progress_addr", mem_addr, 325);
    pulse();
    tick();
    pulse();
    check("s6_underrun", underrun, 1);
    check("s6_restart_req", mem_req, 1);
    check("s6_restart_addr", mem_addr, 640);
    tick();
    check("s6_next_word", mem_addr, 641);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
